conv_y_quant_fifo: RTL and testbench
====================================

Name: conv_y_quant_fifo

Overview:
Downstream stage of conv_8_4. It consumes the 18-bit signed convolution results over a valid/ready handshake and requantises each one with a rounding arithmetic shift and signed saturation. Results are buffered in a small FIFO and streamed to the next layer over a second valid/ready handshake. The block also counts outputs per frame (8-input, 4-tap, so 5 outputs) and pulses a frame-done strobe.

Parameters:
IN_W, 18, width of incoming signed result
OUT_W, 8, width of requantised signed output
SHIFT, 2, arithmetic right-shift amount (0..IN_W-1)
DEPTH, 4, FIFO entries (power of two, >=2)
LOGDEPTH, 2, log2(DEPTH)
NUM_OUT, 5, outputs per frame

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
s_data_in_y  in  IN_W  signed result from conv_8_4
s_valid_y  in  1  upstream valid
s_ready_y  out  1  upstream ready
m_data_out_q  out  OUT_W  signed requantised value, FIFO head
m_valid_q  out  1  downstream valid
m_ready_q  in  1  downstream ready
frame_done  out  1  one-cycle pulse on the pop of the NUM_OUT-th output of a frame
sat_flag  out  1  sticky: some accepted value saturated

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: s_ready_y=0 during reset, then 1 on the first cycle after reset. m_valid_q=0, m_data_out_q=0, frame_done=0, sat_flag=0. FIFO count, read/write pointers and frame counter all 0.
- Reset mid-operation discards all buffered entries and the frame count.
- Accept: a write occurs at a clock edge where s_valid_y && s_ready_y.
- s_ready_y = !reset_q && (count != DEPTH). It is a registered-state function only and never depends on m_ready_q, so there is no write-through when full.
- Pop: a pop occurs at an edge where m_valid_q && m_ready_q. m_valid_q = (count != 0). m_data_out_q = mem[rd_ptr].
- Simultaneous write and pop leaves count unchanged. Both pointers advance and wrap modulo DEPTH.
- Latency: a value accepted at edge N appears at the head at N+1 if the FIFO was empty. There is no empty bypass.
- Quantise, combinational on input before write:
  - Sign-extend to IN_W+1 bits.
  - If SHIFT>0, add 2^(SHIFT-1), then arithmetic shift right by SHIFT. This is round-half-up toward +inf.
  - Saturate to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
- sat_flag sets on an accepted write whose value clamped. It is cleared only by reset.
- Frame counter increments on each pop.
  - On the pop where counter==NUM_OUT-1, frame_done=1 for the following cycle (registered) and the counter returns to 0.
  - The counter is unaffected by writes.
- s_valid_y with the FIFO full: the upstream holds its data; nothing is dropped or overwritten.
- m_valid_q, once asserted, stays high with stable m_data_out_q until popped.

Optional Feature:
QUANT_RELU_EN
- Defined: after saturation, negative values are replaced with 0 before the FIFO write. sat_flag still reflects the clamp at the saturation step only.
- Undefined: signed values pass unchanged. No ReLU logic is synthesised.

Decomposition:
- Package conv_pkg holds:
  - constants X_LEN=8, F_LEN=4, Y_LEN=X_LEN-F_LEN+1, Y_W=18, Q_W=8;
  - typedefs y_t (logic signed [Y_W-1:0]) and q_t (logic signed [Q_W-1:0]);
  - function sat_round(y_t, shift) returning q_t plus a sat bit.
- One sub-module is natural: sync_fifo (parameterised WIDTH/DEPTH/LOGDEPTH) with count, full/empty, wr/rd handshake. conv_y_quant_fifo wraps it with quantise and frame logic.

Test Plan:
- Values accepted in order 100, -6, 1000, -1000 (m_ready_q=1) -> outputs in order 25, -1, 127, -128; sat_flag=1 after the third accept.
- With m_ready_q=0, push 6 values -> s_ready_y drops after 4 accepts, the 5th is held by upstream. Raise m_ready_q -> all 6 emerge in order with no loss.
- Push/pop 10 values continuously -> frame_done pulses exactly twice, on the cycle after the 5th and 10th pops.
- Assert reset with 3 entries buffered -> next cycle m_valid_q=0 and count=0. The frame counter restarts: the next 5 pops give one frame_done.
- Full FIFO with s_valid_y=1 and m_ready_q=1 on the same cycle -> pop occurs, no write. Write occurs next cycle when s_ready_y=1.
- With QUANT_RELU_EN defined, input -6 -> output 0, and input 1000 -> 127.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, types and the rounding/saturating requantiser for the conv_8_4 output path.
package conv_pkg;

    localparam int X_LEN = 8;
    localparam int F_LEN = 4;
    localparam int Y_LEN = X_LEN - F_LEN + 1;
    localparam int Y_W   = 18;
    localparam int Q_W   = 8;

    typedef logic signed [Y_W-1:0] y_t;
    typedef logic signed [Q_W-1:0] q_t;

    typedef struct packed {
        logic sat;
        q_t   q;
    } sat_round_t;

    localparam logic signed [Y_W:0] Q_MAX_EXT = (Y_W+1)'((1 << (Q_W-1)) - 1);
    localparam logic signed [Y_W:0] Q_MIN_EXT = ~Q_MAX_EXT;

    // Round half up toward +inf, then clamp; one guard bit absorbs the rounding carry.
    function automatic sat_round_t sat_round(input y_t y, input logic [4:0] shift);
        logic signed [Y_W:0] ext;
        logic signed [Y_W:0] rnd;
        sat_round_t          r;
        ext = {y[Y_W-1], y};
        rnd = '0;
        if (shift != 5'd0)
            rnd[shift - 5'd1] = 1'b1;
        ext = (ext + rnd) >>> shift;
        r.sat = 1'b0;
        r.q   = ext[Q_W-1:0];
        if (ext > Q_MAX_EXT) begin
            r.sat = 1'b1;
            r.q   = Q_MAX_EXT[Q_W-1:0];
        end else if (ext < Q_MIN_EXT) begin
            r.sat = 1'b1;
            r.q   = Q_MIN_EXT[Q_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_y_quant_fifo_sync_fifo.sv
// Synchronous FIFO (module sync_fifo): callers qualify wr_en/rd_en with full/empty.
module sync_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int LOGDEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [LOGDEPTH-1:0] wr_ptr;
    logic [LOGDEPTH-1:0] rd_ptr;
    logic [LOGDEPTH:0]   count;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (LOGDEPTH+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/conv_y_quant_fifo.sv
// Requantise conv_8_4 results, buffer them and count outputs per frame.
// Optional macro QUANT_RELU_EN: zero negative results after saturation.
import conv_pkg::*;

module conv_y_quant_fifo #(
    parameter int IN_W     = 18,
    parameter int OUT_W    = 8,
    parameter int SHIFT    = 2,
    parameter int DEPTH    = 4,
    parameter int LOGDEPTH = 2,
    parameter int NUM_OUT  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  s_data_in_y,
    input  logic                    s_valid_y,
    output logic                    s_ready_y,
    output logic signed [OUT_W-1:0] m_data_out_q,
    output logic                    m_valid_q,
    input  logic                    m_ready_q,
    output logic                    frame_done,
    output logic                    sat_flag
);

    localparam int FW = $clog2(NUM_OUT + 1);

    logic                    reset_q;
    y_t                      y_in;
    sat_round_t              quant;
    logic signed [OUT_W-1:0] wr_data;
    logic signed [OUT_W-1:0] head;
    logic                    wr;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic [FW-1:0]           frame_cnt;

    assign y_in = s_data_in_y;

    always_comb begin
        quant   = sat_round(y_in, 5'(SHIFT));
        wr_data = quant.q;
`ifdef QUANT_RELU_EN
        if (quant.q[Q_W-1])
            wr_data = '0;
`endif
    end

    // Readiness depends only on registered state, so a full FIFO never writes through.
    assign s_ready_y = !reset_q && !full;
    assign wr        = s_valid_y && s_ready_y;
    assign m_valid_q = !empty;
    assign pop       = m_valid_q && m_ready_q;

    sync_fifo #(
        .WIDTH    (OUT_W),
        .DEPTH    (DEPTH),
        .LOGDEPTH (LOGDEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign m_data_out_q = empty ? '0 : head;

    always_ff @(posedge clk) begin
        if (reset) begin
            reset_q    <= 1'b1;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            reset_q    <= 1'b0;
            frame_done <= 1'b0;
            if (wr && quant.sat)
                sat_flag <= 1'b1;
            if (pop) begin
                if (frame_cnt == FW'(NUM_OUT - 1)) begin
                    frame_cnt  <= '0;
                    frame_done <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_y_quant_fifo.sv
// Bench for conv_y_quant_fifo: table vectors, handshake corner cases and a randomized scoreboard run.
module tb_conv_y_quant_fifo;

    localparam int IN_W    = 18;
    localparam int OUT_W   = 8;
    localparam int SHIFT   = 2;
    localparam int NUM_OUT = 5;
    localparam int QMAX    = (1 << (OUT_W-1)) - 1;
    localparam int QMIN    = -(1 << (OUT_W-1));

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic signed [IN_W-1:0]  s_data_in_y = '0;
    logic                    s_valid_y = 1'b0;
    logic                    s_ready_y;
    logic signed [OUT_W-1:0] m_data_out_q;
    logic                    m_valid_q;
    logic                    m_ready_q = 1'b0;
    logic                    frame_done;
    logic                    sat_flag;

    int nvec = 0;
    int nerr = 0;
    int exp_q[$];
    int pop_cnt = 0;
    int fd_cnt = 0;
    bit fd_pending = 0;
    bit stress_done = 0;

    typedef struct {
        int in;
        int out;
        bit sat;
    } vec_t;
    vec_t tbl[14];

    conv_y_quant_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_y  (s_data_in_y),
        .s_valid_y    (s_valid_y),
        .s_ready_y    (s_ready_y),
        .m_data_out_q (m_data_out_q),
        .m_valid_q    (m_valid_q),
        .m_ready_q    (m_ready_q),
        .frame_done   (frame_done),
        .sat_flag     (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int relu(input int v);
`ifdef QUANT_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Reference: floor((x + 2^(SHIFT-1)) / 2^SHIFT) clamped to the output range.
    function automatic int model_q(input int x, output bit sat);
        int t;
        t = x + ((SHIFT > 0) ? (1 << (SHIFT-1)) : 0);
        t = t >>> SHIFT;
        sat = 0;
        if (t > QMAX) begin t = QMAX; sat = 1; end
        else if (t < QMIN) begin t = QMIN; sat = 1; end
        return relu(t);
    endfunction

    function automatic int q_of(input int x);
        bit s;
        return model_q(x, s);
    endfunction

    task automatic model_push(input int v);
        exp_q.push_back(q_of(v));
    endtask

    task automatic push(input int v);
        bit ok;
        ok = 0;
        s_data_in_y = IN_W'(v);
        s_valid_y = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (s_ready_y === 1'b1) begin
                model_push(v);
                @(posedge clk);
                @(negedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        s_valid_y = 1'b0;
        if (!ok) check("push_timeout", 0, 1);
    endtask

    task automatic drain();
        m_ready_q = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (m_valid_q !== 1'b1) break;
            @(negedge clk);
        end
        check("drain_empty", m_valid_q, 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_valid_y = 1'b0;
        @(negedge clk);
        check("rst_valid", m_valid_q, 0);
        check("rst_data", m_data_out_q, 0);
        check("rst_ready", s_ready_y, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_fd", frame_done, 0);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_rst", s_ready_y, 1);
        fd_cnt = 0;
    endtask

    // Monitor: scoreboard on pops and frame_done prediction, sampled just after the falling edge.
    always @(negedge clk) begin
        #1;
        if (reset) begin
            exp_q.delete();
            pop_cnt = 0;
            fd_pending = 0;
        end else begin
            check("frame_done", frame_done, fd_pending);
            if (frame_done === 1'b1) fd_cnt++;
            fd_pending = 0;
            if (m_valid_q === 1'b1 && m_ready_q === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 1, 0);
                end else begin
                    check("pop_data", m_data_out_q, exp_q.pop_front());
                end
                pop_cnt++;
                fd_pending = (pop_cnt % NUM_OUT) == 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  v[6];
        bit  sticky;
        logic signed [IN_W-1:0] r;

        tbl[0]  = '{100, 25, 0};
        tbl[1]  = '{-6, -1, 0};
        tbl[2]  = '{1000, 127, 1};
        tbl[3]  = '{-1000, -128, 1};
        tbl[4]  = '{2, 1, 0};
        tbl[5]  = '{1, 0, 0};
        tbl[6]  = '{-2, 0, 0};
        tbl[7]  = '{-3, -1, 0};
        tbl[8]  = '{509, 127, 0};
        tbl[9]  = '{510, 127, 1};
        tbl[10] = '{-514, -128, 0};
        tbl[11] = '{-515, -128, 1};
        tbl[12] = '{131071, 127, 1};
        tbl[13] = '{-131072, -128, 1};

        @(negedge clk);
        do_reset();

        // Table: quantisation and sticky saturation.
        m_ready_q = 1'b1;
        sticky = 0;
        foreach (tbl[i]) begin
            push(tbl[i].in);
            sticky |= tbl[i].sat;
            check("tbl_valid", m_valid_q, 1);
            check("tbl_out", m_data_out_q, relu(tbl[i].out));
            check("tbl_sat", sat_flag, sticky);
        end
        drain();

        // Backpressure: 4 fill the FIFO, the 5th is held, then all 6 emerge in order.
        do_reset();
        m_ready_q = 1'b0;
        for (int i = 0; i < 6; i++) v[i] = (i * 37) - 90;
        for (int i = 0; i < 4; i++) push(v[i]);
        check("full_ready", s_ready_y, 0);
        s_data_in_y = IN_W'(v[4]);
        s_valid_y = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("held_ready", s_ready_y, 0);
        end
        check("held_head", m_data_out_q, q_of(v[0]));
        m_ready_q = 1'b1;
        push(v[4]);
        push(v[5]);
        drain();
        check("bp_pops", pop_cnt, 6);
        check("sb_empty_bp", exp_q.size(), 0);

        // Ten continuous values: two frame_done pulses.
        do_reset();
        m_ready_q = 1'b1;
        for (int i = 0; i < 10; i++) begin
            r = IN_W'($urandom);
            push(int'(r));
        end
        drain();
        check("fd_twice", fd_cnt, 2);

        // Reset with three buffered entries, then frame counting restarts.
        m_ready_q = 1'b0;
        for (int i = 0; i < 3; i++) push(i * 100 + 4);
        check("pre_rst_valid", m_valid_q, 1);
        do_reset();
        m_ready_q = 1'b1;
        for (int i = 0; i < 5; i++) push(i * 8 - 20);
        drain();
        check("fd_after_rst", fd_cnt, 1);

        // Full FIFO with valid and ready together: pop first, write next cycle.
        do_reset();
        m_ready_q = 1'b0;
        for (int i = 0; i < 4; i++) push(i * 12 + 1);
        check("full_ready2", s_ready_y, 0);
        s_data_in_y = IN_W'(777);
        s_valid_y = 1'b1;
        m_ready_q = 1'b1;
        @(negedge clk);
        check("full_pop_head", m_data_out_q, q_of(13));
        check("full_ready_after", s_ready_y, 1);
        model_push(777);
        @(negedge clk);
        s_valid_y = 1'b0;
        drain();
        check("sb_empty_full", exp_q.size(), 0);

        // Randomized stress with a toggling downstream ready.
        do_reset();
        stress_done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if (i % 2 == 0) r = IN_W'($urandom);
                    else r = IN_W'($urandom_range(0, 1200) - 600);
                    push(int'(r));
                end
                stress_done = 1;
            end
            begin
                while (!stress_done) begin
                    @(negedge clk);
                    m_ready_q = 1'($urandom % 2);
                end
            end
        join
        drain();
        check("sb_empty_rand", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
